// File: rtl/apb_mem_arbiter_if.sv
// Requester command/response and APB bus signals of the two-port APB memory arbiter.
// The arbiter uses the master view. The requesters and the memory slave use the slave view.
interface apb_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0_i, req1_i;
  logic              we0_i, we1_i;
  logic [ADDR_W-1:0] addr0_i, addr1_i;
  logic [DATA_W-1:0] wdata0_i, wdata1_i;
  logic              gnt0_o, gnt1_o;
  logic              done0_o, done1_o;
  logic [DATA_W-1:0] rdata0_o, rdata1_o;
  logic              err0_o, err1_o;
  logic              psel_o, penable_o, pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i, pslverr_i;

  modport master (
    input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output gnt0_o, gnt1_o, done0_o, done1_o, rdata0_o, rdata1_o, err0_o, err1_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  gnt0_o, gnt1_o, done0_o, done1_o, rdata0_o, rdata1_o, err0_o, err1_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/apb_mem_arbiter.sv
// Two-requester round-robin APB master in front of a single APB memory slave.
// Each requester gets a gnt pulse on SETUP and a done/err/rdata response after ACCESS or a timeout.

module apb_mem_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              cpl_i,
  input  logic              err_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic              done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // rdata holds between read completions; writes and timeouts leave it alone
  always_comb begin
    done_d  = cpl_i;
    err_d   = cpl_i & err_i;
    rdata_d = (cpl_i & load_i) ? rdata_i : rdata_q;
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
endmodule

module apb_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk_i,
  input  logic               prst_i,
  apb_mem_arbiter_if.master  bus
);
  localparam int NP    = 2;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [NP-1:0]             req, we;
  logic [NP-1:0][ADDR_W-1:0] addr;
  logic [NP-1:0][DATA_W-1:0] wdata;

  assign req   = {bus.req1_i, bus.req0_i};
  assign we    = {bus.we1_i, bus.we0_i};
  assign addr  = {bus.addr1_i, bus.addr0_i};
  assign wdata = {bus.wdata1_i, bus.wdata0_i};

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [NP-1:0]     gnt_q, gnt_d;

  logic              pick, launch, finish;
  logic [NP-1:0]     cpl;
  logic              cpl_err, cpl_load;

  // On a tie the port that was not granted last wins
  assign pick = (req[0] & req[1]) ? ~last_q : req[1];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    gnt_d     = '0;
    cpl       = '0;
    cpl_err   = 1'b0;
    cpl_load  = 1'b0;
    launch    = 1'b0;
    finish    = 1'b0;

    case (state_q)
      S_IDLE: begin
        launch = |req;
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (bus.pready_i) begin
          cpl[win_q] = 1'b1;
          cpl_err    = bus.pslverr_i;
          cpl_load   = ~pwrite_q;
          finish     = 1'b1;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          cpl[win_q] = 1'b1;
          cpl_err    = 1'b1;
          finish     = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (finish) begin
          cnt_d = '0;
          if (|req) begin
            launch = 1'b1;
          end else begin
            state_d   = S_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        cnt_d     = '0;
      end
    endcase

    // Launch straight into SETUP so back-to-back transfers skip IDLE
    if (launch) begin
      state_d     = S_SETUP;
      psel_d      = 1'b1;
      penable_d   = 1'b0;
      win_d       = pick;
      last_d      = pick;
      gnt_d[pick] = 1'b1;
      pwrite_d    = we[pick];
      paddr_d     = addr[pick];
      pwdata_d    = we[pick] ? wdata[pick] : '0;
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      gnt_q     <= gnt_d;
    end
  end

  logic [NP-1:0]             done_w, err_w;
  logic [NP-1:0][DATA_W-1:0] rdata_w;

  for (genvar p = 0; p < NP; p++) begin : g_port
    apb_mem_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .pclk_i  (pclk_i),
      .prst_i  (prst_i),
      .cpl_i   (cpl[p]),
      .err_i   (cpl_err),
      .load_i  (cpl_load),
      .rdata_i (bus.prdata_i),
      .done_o  (done_w[p]),
      .err_o   (err_w[p]),
      .rdata_o (rdata_w[p])
    );
  end

  assign bus.gnt0_o    = gnt_q[0];
  assign bus.gnt1_o    = gnt_q[1];
  assign bus.done0_o   = done_w[0];
  assign bus.done1_o   = done_w[1];
  assign bus.err0_o    = err_w[0];
  assign bus.err1_o    = err_w[1];
  assign bus.rdata0_o  = rdata_w[0];
  assign bus.rdata1_o  = rdata_w[1];
  assign bus.psel_o    = psel_q;
  assign bus.penable_o = penable_q;
  assign bus.pwrite_o  = pwrite_q;
  assign bus.paddr_o   = paddr_q;
  assign bus.pwdata_o  = pwdata_q;
endmodule
